// File: rtl/gf128_reduce.sv
// Multi-cycle reduction of a 256-bit carry-less product modulo x^128 + x^7 + x^2 + x + 1.
// Folds FOLD high-order bits per clock, so a result is ready 128/FOLD cycles after it is accepted.
module gf128_reduce #(
    parameter int unsigned FOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_prod,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_res,
    output logic         busy
);

    localparam int unsigned STEPS    = 128 / FOLD;
    localparam int unsigned CntWidth = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [255:0]          r_q, r_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;

    logic [8:0]            lo;
    logic [FOLD-1:0]       win;
    logic [255:0]          win_ext;
    logic [255:0]          r_fold;

    // Window r[lo+FOLD-1:lo] is cleared and reflected into x^0, x^1, x^2, x^7
    // relative to bit (i-128); every target sits below the window.
    always_comb begin
        lo      = 9'(256 - (int'(cnt_q) + 1) * int'(FOLD));
        win     = FOLD'(r_q >> lo);
        win_ext = 256'(win);
        r_fold  = r_q
                ^ (win_ext << lo)
                ^ (win_ext << (lo - 9'd128))
                ^ (win_ext << (lo - 9'd127))
                ^ (win_ext << (lo - 9'd126))
                ^ (win_ext << (lo - 9'd121));
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    r_d     = in_prod;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                r_d   = r_fold;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntWidth'(STEPS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign out_res   = r_q[127:0];

endmodule

// File: tb/tb_gf128_reduce.sv
// Bench for gf128_reduce: four FOLD builds share stimulus and are checked against
// a long-division reference of the product modulo P(x).
module tb_gf128_reduce;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [255:0] in_prod;
    logic         out_ready;

    logic         ir [4];
    logic         ov [4];
    logic         bz [4];
    logic [127:0] res [4];

    int checks = 0;
    int errors = 0;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        gf128_reduce #(.FOLD(8 << k)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir[k]),
            .in_prod  (in_prod),
            .out_valid(ov[k]),
            .out_ready(out_ready),
            .out_res  (res[k]),
            .busy     (bz[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: polynomial long division, highest term first.
    function automatic logic [127:0] ref_mod(input logic [255:0] a);
        logic [255:0] poly;
        poly      = '0;
        poly[128] = 1'b1;
        poly[7:0] = 8'h87;
        for (int i = 255; i >= 128; i--) begin
            if (a[i]) a = a ^ (poly << (i - 128));
        end
        return a[127:0];
    endfunction

    function automatic int steps_of(input int k);
        return 128 / (8 << k);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic wait_all_idle();
        int n;
        n = 0;
        while (!(ir[0] && ir[1] && ir[2] && ir[3]) && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
    endtask

    // Called at the negedge right after the accept edge; watches the masked instances.
    task automatic collect(input string tag, input logic [127:0] exp, input logic [3:0] mask);
        logic [3:0] got;
        int n;
        got = ~mask;
        n = 0;
        while (got != 4'hf && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            for (int k = 0; k < 4; k++) begin
                if (!got[k] && ov[k]) begin
                    check($sformatf("%s_lat_f%0d", tag, 8 << k), n, steps_of(k));
                    check($sformatf("%s_res_f%0d", tag, 8 << k), res[k], exp);
                    got[k] = 1'b1;
                end
            end
        end
        if (got != 4'hf) check($sformatf("%s_timeout", tag), got, 4'hf);
    endtask

    task automatic run_one(input string tag, input logic [255:0] prod, input logic [127:0] exp);
        wait_all_idle();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_prod   = prod;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_prod  = rand256();
        collect(tag, exp, 4'hf);
    endtask

    logic [255:0] a, b, c;
    logic [255:0] ones;
    logic [127:0] exp_q [$];
    int           acc_cyc [$];
    int           idx, nres, cyc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_in_ready_f%0d", 8 << k), ir[k], 1'b1);
            check($sformatf("rst_out_valid_f%0d", 8 << k), ov[k], 1'b0);
            check($sformatf("rst_busy_f%0d", 8 << k), bz[k], 1'b0);
            check($sformatf("rst_out_res_f%0d", 8 << k), res[k], 128'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        a = '0; a[128] = 1'b1;
        run_one("x128", a, 128'h87);
        a = '0; a[129] = 1'b1;
        run_one("x129", a, 128'h10E);
        a = {128'h0, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98};
        run_one("lowhalf", a, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);
        ones = '1;
        run_one("allones", ones, ref_mod(ones));
        a = '0; a[255] = 1'b1;
        run_one("x255", a, ref_mod(a));

        // Backpressure on the FOLD=16 build
        wait_all_idle();
        a = rand256();
        b = rand256();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_prod   = a;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        idx = 0;
        while (!ov[1] && idx < 40) begin
            @(posedge clk);
            @(negedge clk);
            idx++;
        end
        check("bp_latency", idx, 8);
        in_valid = 1'b1;
        in_prod  = b;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_res", res[1], ref_mod(a));
            check("bp_hold_in_ready", ir[1], 1'b0);
            check("bp_hold_out_valid", ov[1], 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_after_hs_idle", ir[1], 1'b1);
        check("bp_after_hs_busy", bz[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_busy", bz[1], 1'b1);
        collect("bp_second", ref_mod(b), 4'b0010);
        wait_all_idle();

        // Asynchronous reset mid-run at cnt==3 (FOLD=16)
        a = rand256();
        in_valid = 1'b1;
        in_prod  = a;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", bz[1], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", ir[1], 1'b1);
        check("arst_out_valid", ov[1], 1'b0);
        check("arst_busy", bz[1], 1'b0);
        check("arst_out_res", res[1], 128'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("arst_no_out_valid", ov[1], 1'b0);
        end
        c = rand256();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_prod  = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("release_accept", bz[1], 1'b1);
        collect("post_rst", ref_mod(c), 4'hf);

        // Back-to-back with out_ready tied high (FOLD=16)
        wait_all_idle();
        out_ready = 1'b1;
        idx  = 0;
        nres = 0;
        for (cyc = 0; cyc < 300 && nres < 6; cyc++) begin
            if (ov[1]) begin
                if (exp_q.size() == 0) begin
                    check("b2b_extra_result", 1, 0);
                end else begin
                    check("b2b_res", res[1], exp_q.pop_front());
                    nres++;
                end
            end
            if (ir[1]) begin
                if (idx < 6) begin
                    a        = rand256();
                    in_valid = 1'b1;
                    in_prod  = a;
                    exp_q.push_back(ref_mod(a));
                    acc_cyc.push_back(cyc);
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_count", nres, 6);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 10);
        end
        wait_all_idle();

        // Randomized products, all four builds
        for (int t = 0; t < 2000; t++) begin
            a = rand256();
            case ($urandom_range(0, 7))
                0: a[255:128] = '0;
                1: a = a & rand256() & rand256();
                2: a = a | rand256() | rand256();
                default: ;
            endcase
            run_one("rand", a, ref_mod(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
